// File: rtl/fetch_if.sv
// Fetch-stage bus: memory fetch port, decode handshake, branch/halt control.
interface fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic [ADDR_W-1:0]  mem_pc;
    logic [INSTR_W-1:0] mem_instr;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               halt;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               halted;

    // Fetch unit side
    modport master (
        output mem_pc,
        input  mem_instr,
        input  branch_taken,
        input  branch_target,
        input  halt,
        output instr_valid,
        output instr_out,
        output instr_pc,
        input  instr_ready,
        output halted
    );

    // Memory / decode / execute side
    modport slave (
        input  mem_pc,
        output mem_instr,
        output branch_taken,
        output branch_target,
        output halt,
        input  instr_valid,
        input  instr_out,
        input  instr_pc,
        output instr_ready,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one byte per cycle from a
// combinational memory and queues {pc, byte} pairs for decode.
module fetch_unit #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 8,
    parameter int                QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]   r_q_pc    [QUEUE_DEPTH];
    logic [INSTR_W-1:0]  r_q_instr [QUEUE_DEPTH];

    logic w_pop;
    logic w_push;
    logic w_has_room;

    assign w_pop      = (r_count != '0) && bus.instr_ready;
    // A full queue can still take a byte when the head leaves this cycle.
    assign w_has_room = (r_count < CNT_W'(QUEUE_DEPTH)) || w_pop;
    assign w_push     = (r_state == RUN) && !bus.halt && !bus.branch_taken && w_has_room;

    // FSM, PC, pointers and occupancy; branch flushes everything below reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state <= bus.halt ? HALT : RUN;
            if (bus.branch_taken) begin
                r_fetch_pc <= bus.branch_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                    r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= bus.mem_instr;
        end
    end

    assign bus.mem_pc      = r_fetch_pc;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr_out   = r_q_instr[r_rd_ptr];
    assign bus.instr_pc    = r_q_pc[r_rd_ptr];
    assign bus.halted      = (r_state == HALT) && (r_count == '0);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural 256x8 memory.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;

    fetch_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

    fetch_unit #(.ADDR_W(8), .INSTR_W(8), .QUEUE_DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign bus.mem_instr = mem[bus.mem_pc];

    typedef struct {
        logic       rst, br;
        logic [7:0] tgt;
        logic       hlt, rdy;
        logic       chk, chkd;
        logic       ev;
        logic [7:0] eo, ep, em;
        logic       eh;
    } vec_t;

    localparam int NV = 33;
    vec_t tv [NV];
    int n_chk = 0;
    int n_pass = 0;

    function automatic vec_t mk(logic rst, logic br, logic [7:0] tgt, logic hlt, logic rdy,
                                logic chk, logic chkd, logic ev, logic [7:0] eo,
                                logic [7:0] ep, logic [7:0] em, logic eh);
        vec_t v;
        v.rst = rst; v.br = br; v.tgt = tgt; v.hlt = hlt; v.rdy = rdy;
        v.chk = chk; v.chkd = chkd; v.ev = ev; v.eo = eo; v.ep = ep; v.em = em; v.eh = eh;
        return v;
    endfunction

    task automatic cmp(string name, int idx, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec=%0d got=%02h expected=%02h", name, idx, act, exp);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2; mem[8'h02] = 8'hC3; mem[8'h40] = 8'h5E;

        //            rst br tgt    hlt rdy  chk chkd ev eo     ep     em     eh
        tv[0]  = mk(1, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        tv[1]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        tv[2]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hA1, 8'h00, 8'h01, 0);
        tv[3]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hB2, 8'h01, 8'h02, 0);
        tv[4]  = mk(1, 0, 8'h00, 0, 0,  1, 1, 1, 8'hC3, 8'h02, 8'h03, 0);
        tv[5]  = mk(0, 0, 8'h00, 0, 0,  1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        tv[6]  = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'hA1, 8'h00, 8'h01, 0);
        tv[7]  = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'hA1, 8'h00, 8'h02, 0);
        tv[8]  = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'hA1, 8'h00, 8'h02, 0);
        tv[9]  = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'hA1, 8'h00, 8'h02, 0);
        tv[10] = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hA1, 8'h00, 8'h02, 0);
        tv[11] = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hB2, 8'h01, 8'h03, 0);
        tv[12] = mk(0, 1, 8'h40, 0, 0,  1, 1, 1, 8'hC3, 8'h02, 8'h04, 0);
        tv[13] = mk(0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 8'h00, 8'h40, 0);
        tv[14] = mk(0, 1, 8'hFE, 0, 1,  1, 1, 1, 8'h5E, 8'h40, 8'h41, 0);
        tv[15] = mk(0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 8'h00, 8'hFE, 0);
        tv[16] = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hA4, 8'hFE, 8'hFF, 0);
        tv[17] = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hA5, 8'hFF, 8'h00, 0);
        tv[18] = mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 8'hA1, 8'h00, 8'h01, 0);
        tv[19] = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'hB2, 8'h01, 8'h02, 0);
        tv[20] = mk(0, 0, 8'h00, 1, 1,  1, 1, 1, 8'hB2, 8'h01, 8'h03, 0);
        tv[21] = mk(0, 0, 8'h00, 1, 1,  1, 1, 1, 8'hC3, 8'h02, 8'h03, 0);
        tv[22] = mk(0, 0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 8'h00, 8'h03, 1);
        tv[23] = mk(0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 8'h00, 8'h03, 1);
        tv[24] = mk(0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 8'h00, 8'h03, 0);
        tv[25] = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'h59, 8'h03, 8'h04, 0);
        tv[26] = mk(1, 1, 8'h77, 0, 0,  1, 1, 1, 8'h59, 8'h03, 8'h05, 0);
        tv[27] = mk(0, 0, 8'h00, 0, 0,  1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        tv[28] = mk(0, 1, 8'h40, 1, 0,  1, 1, 1, 8'hA1, 8'h00, 8'h01, 0);
        tv[29] = mk(0, 0, 8'h00, 1, 0,  1, 0, 0, 8'h00, 8'h00, 8'h40, 1);
        tv[30] = mk(0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 8'h00, 8'h40, 1);
        tv[31] = mk(0, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 8'h00, 8'h40, 0);
        tv[32] = mk(0, 0, 8'h00, 0, 0,  1, 1, 1, 8'h5E, 8'h40, 8'h41, 0);

        reset = 1'b1;
        bus.branch_taken = 1'b0; bus.branch_target = 8'h00;
        bus.halt = 1'b0; bus.instr_ready = 1'b0;

        // Each vector: check outputs for the current cycle, then drive the inputs
        // that the next rising edge consumes.
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            if (tv[k].chk) begin
                cmp("instr_valid", k, 8'(bus.instr_valid), 8'(tv[k].ev));
                cmp("mem_pc",      k, bus.mem_pc,          tv[k].em);
                cmp("halted",      k, 8'(bus.halted),      8'(tv[k].eh));
                if (tv[k].chkd) begin
                    cmp("instr_out", k, bus.instr_out, tv[k].eo);
                    cmp("instr_pc",  k, bus.instr_pc,  tv[k].ep);
                end
            end
            reset            = tv[k].rst;
            bus.branch_taken = tv[k].br;
            bus.branch_target = tv[k].tgt;
            bus.halt         = tv[k].hlt;
            bus.instr_ready  = tv[k].rdy;
        end

        // Fetch latency after reset release, with a bounded wait.
        @(negedge clk);
        reset = 1'b1; bus.branch_taken = 1'b0; bus.halt = 1'b0; bus.instr_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        while (!bus.instr_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        cmp("first_valid_latency", NV, 8'(lat), 8'd1);
        cmp("first_instr", NV, bus.instr_out, 8'hA1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
